// File: rtl/sdrahb_ram_rd_stream_if.sv
// Bus bundle for the RAM read-side sequencer: command inputs, RAM read
// port, output stream and debug visibility.
// Stream handshake: a word transfers on a clock edge where out_valid and
// out_ready are both high; once out_valid is raised, out_data and
// out_valid hold until that transfer (only abort or reset may retract them).
interface sdrahb_ram_rd_stream_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic [1:0]            dbg_state;
    logic [1:0]            dbg_fifo_cnt;

    modport slave (
        input  start, start_addr, burst_len, abort, ram_rdata, out_ready,
        output rd_addr, out_data, out_valid, busy, done, dbg_state, dbg_fifo_cnt
    );

    modport master (
        output start, start_addr, burst_len, abort, ram_rdata, out_ready,
        input  rd_addr, out_data, out_valid, busy, done, dbg_state, dbg_fifo_cnt
    );
endinterface

// File: rtl/sdrahb_ram_rd_stream.sv
// Read-side sequencer for the SDRAHB dual-port RAM buffer. Walks rd_addr
// through a burst, absorbs the RAM's one-cycle read latency and presents
// the words through a 2-entry skid FIFO as a valid/ready stream.
module sdrahb_ram_rd_stream #(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5
) (
    input logic                  clk,
    input logic                  reset_n,
    sdrahb_ram_rd_stream_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    logic                  pop;
    logic                  push;
    logic [2:0]            occ;
    logic                  issue;
    logic                  drain_exit;
    logic [ADDR_WIDTH-1:0] addr_inc;

    // Handshake decode and read-issue decision; occupancy counts the word in
    // flight so the FIFO can never be asked to hold a third word.
    always_comb begin
        pop        = (cnt_q != 2'd0) && bus.out_ready;
        push       = inflight_q;
        occ        = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == S_RUN) && (remain_q != '0) && (occ < 3'd2) && !bus.abort;
        addr_inc   = (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        drain_exit = !inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start && (bus.burst_len != '0)) state_d = S_RUN;
                S_RUN:   if (issue && (remain_q == LEN_WIDTH'(1))) state_d = S_DRAIN;
                S_DRAIN: if (drain_exit) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        bus.busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
        bus.rd_addr      = addr_q;
        bus.out_data     = head_q;
        bus.out_valid    = (cnt_q != 2'd0);
        bus.done         = done_q;
        bus.dbg_state    = state_q;
        bus.dbg_fifo_cnt = cnt_q;
    end

    // Address, remaining-length, in-flight and done-pulse next values.
    always_comb begin
        addr_d     = addr_q;
        remain_d   = remain_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        if (bus.abort) begin
            remain_d = '0;
        end else begin
            if ((state_q == S_IDLE) && bus.start) begin
                addr_d   = bus.start_addr;
                remain_d = bus.burst_len;
                done_d   = (bus.burst_len == '0);
            end
            if (issue) begin
                addr_d     = addr_inc;
                remain_d   = remain_q - LEN_WIDTH'(1);
                inflight_d = 1'b1;
            end
            if ((state_q == S_DRAIN) && drain_exit) done_d = 1'b1;
        end
    end

    // Skid FIFO next values: head is the stream output, tail the second slot.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        if (bus.abort) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_d = bus.ram_rdata;
                    end else begin
                        head_d = tail_q;
                        tail_d = bus.ram_rdata;
                    end
                end
                2'b01: begin
                    head_d = tail_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) head_d = bus.ram_rdata;
                    else               tail_d = bus.ram_rdata;
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Datapath and FIFO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end
endmodule

// File: tb/tb_sdrahb_ram_rd_stream.sv
// Directed bench for the RAM read-side sequencer with a behavioural
// registered-read RAM holding mem[i] = i.
module tb_sdrahb_ram_rd_stream;
    logic clk;
    logic reset_n;

    sdrahb_ram_rd_stream_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LEN_WIDTH(5)) bus ();

    sdrahb_ram_rd_stream #(
        .MEM_DEPTH(1024), .ADDR_WIDTH(10), .DATA_WIDTH(32), .LEN_WIDTH(5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:1023];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle registered read.
    initial for (int i = 0; i < 1024; i++) mem[i] = i;
    always @(posedge clk) bus.ram_rdata <= mem[bus.rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [9:0] a, input logic [4:0] l);
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.burst_len  = l;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(32'((first + i) % 1024));
    endtask

    task automatic wait_done(input int max_cyc, input bit bp);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            if (bp) bus.out_ready = (k % 3 == 0);
            tick();
            if (bus.done) seen = 1'b1;
        end
        bus.out_ready = 1'b1;
        check("done_seen", seen, 1);
        tick();
        check("done_one_clk", bus.done, 0);
        check("busy_after_done", bus.busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Scoreboard: every transfer must match the head of exp_q; stalled words must hold.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            check("fifo_cnt_le2", (bus.dbg_fifo_cnt <= 2'd2), 1);
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("extra_word", bus.out_valid, 0);
                else                   check("stream_data", bus.out_data, exp_q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready && !bus.abort;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.burst_len  = '0;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'b0;
        tick(); tick();
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_state", bus.dbg_state, 0);
        reset_n = 1'b1;
        tick(); tick();

        // Full rate: 5,6,7,8 out in clk3..6, done in clk7.
        bus.out_ready = 1'b1;
        push_range(5, 4);
        issue_cmd(10'd5, 5'd4);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) tick();
            check("t1_valid", bus.out_valid, (c >= 3 && c <= 6));
            check("t1_busy", bus.busy, (c <= 6));
            check("t1_done", bus.done, (c == 7));
            if (c <= 4) check("t1_rd_addr", bus.rd_addr, 4 + c);
        end
        tick();
        check("t1_done_low", bus.done, 0);
        check("t1_drained", exp_q.size(), 0);
        tick();

        // Backpressure: ready 1,0,0,1,... over 6 words.
        push_range(100, 6);
        issue_cmd(10'd100, 5'd6);
        wait_done(80, 1'b1);
        tick();

        // Wrap across the end of the RAM.
        push_range(1022, 4);
        issue_cmd(10'd1022, 5'd4);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            check("t3_rd_addr", bus.rd_addr, (1021 + c) % 1024);
        end
        wait_done(20, 1'b0);
        tick();

        // Abort with data stalled in the FIFO.
        push_range(200, 3);
        issue_cmd(10'd200, 5'd16);
        for (int c = 2; c <= 6; c++) tick();
        bus.out_ready = 1'b0;
        tick(); tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t4_valid", bus.out_valid, 0);
        check("t4_busy", bus.busy, 0);
        check("t4_done", bus.done, 0);
        check("t4_rd_addr_hold", bus.rd_addr, 205);
        check("t4_fifo_empty", bus.dbg_fifo_cnt, 0);
        tick();
        check("t4_no_done", bus.done, 0);
        check("t4_valid_low", bus.out_valid, 0);
        check("t4_three_words", exp_q.size(), 0);
        bus.out_ready = 1'b1;
        push_range(300, 3);
        issue_cmd(10'd300, 5'd3);
        wait_done(20, 1'b0);

        // Zero-length command: done next clk, no data.
        issue_cmd(10'd10, 5'd0);
        check("t5_zero_done", bus.done, 1);
        check("t5_zero_busy", bus.busy, 0);
        check("t5_zero_valid", bus.out_valid, 0);
        tick();
        check("t5_zero_done_low", bus.done, 0);
        check("t5_zero_valid_low", bus.out_valid, 0);
        tick();

        // Start while busy is ignored.
        push_range(400, 3);
        issue_cmd(10'd400, 5'd3);
        bus.start      = 1'b1;
        bus.start_addr = 10'd500;
        bus.burst_len  = 5'd7;
        tick();
        bus.start = 1'b0;
        wait_done(20, 1'b0);
        tick();
        check("t5_no_second_burst", bus.out_valid, 0);
        check("t5_idle", bus.busy, 0);

        // Asynchronous reset mid-burst in clk4.
        push_range(600, 1);
        issue_cmd(10'd600, 5'd8);
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        check("t6_valid", bus.out_valid, 0);
        check("t6_rd_addr", bus.rd_addr, 0);
        check("t6_out_data", bus.out_data, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_done", bus.done, 0);
        check("t6_one_word", exp_q.size(), 0);
        tick(); tick();
        reset_n = 1'b1;
        check("t6_state_idle", bus.dbg_state, 0);
        tick();
        check("t6_no_done", bus.done, 0);
        push_range(700, 5);
        issue_cmd(10'd700, 5'd5);
        wait_done(20, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
